cmd_frame_tx: RTL and testbench

//  Host-side command framer that drives SYS_TOP RX_IN. Accepts one command per handshake and

---
 rtl/cmd_frame_tx.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_cmd_frame_tx.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cmd_frame_tx                                                 |
// | Description : Host-side command framer. Accepts one command per handshake  |
// |               and serialises it as a burst of UART frames (start, 8 data   |
// |               bits LSB first, optional parity, stop) at Prescale clocks    |
// |               per bit, with GAP_BITS idle bit periods between bytes.       |
// |               Optional build macro CMD_FRAME_TX_QUEUE_EN adds a 2-entry    |
// |               command FIFO ahead of the framer.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cmd_frame_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int OP_WIDTH   = 4,
    parameter int PRESCALE_W = 6,
    parameter int GAP_BITS   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VLD,
    output logic                  CMD_RDY,
    input  logic [1:0]            CMD_TYPE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_D0,
    input  logic [DATA_WIDTH-1:0] CMD_D1,
    input  logic [OP_WIDTH-1:0]   CMD_FUN,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam logic [1:0]            c_TYPE_WR   = 2'd0;
    localparam logic [1:0]            c_TYPE_RD   = 2'd1;
    localparam logic [1:0]            c_TYPE_ALU  = 2'd2;
    localparam logic [DATA_WIDTH-1:0] c_HDR_WR    = 8'hAA;
    localparam logic [DATA_WIDTH-1:0] c_HDR_RD    = 8'hBB;
    localparam logic [DATA_WIDTH-1:0] c_HDR_ALU   = 8'hCC;
    localparam logic [DATA_WIDTH-1:0] c_HDR_NOP   = 8'hDD;
    localparam logic [PRESCALE_W-1:0] c_PRESC_MIN = PRESCALE_W'(4);
    localparam logic [2:0]            c_LAST_BIT  = 3'(DATA_WIDTH - 1);
    localparam logic [2:0]            c_GAP_LAST  = 3'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    // Everything the framer needs for one command, captured at accept time
    typedef struct packed {
        logic [1:0]            typ;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] d0;
        logic [DATA_WIDTH-1:0] d1;
        logic [OP_WIDTH-1:0]   fun;
        logic                  pe;
        logic                  pt;
        logic [PRESCALE_W-1:0] presc;
    } cmd_t;

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] timer_q, timer_d;
    logic [2:0]            bit_q, bit_d;
    logic [1:0]            byte_q, byte_d;
    logic [2:0]            gap_q, gap_d;
    logic                  tx_q, tx_d;
    cmd_t                  cmd_q, cmd_d;

    cmd_t                  w_in;
    cmd_t                  w_next;
    logic                  w_avail;
    logic                  w_chain;
    logic                  w_load;
    logic                  w_tc;
    logic                  w_last_byte;
    logic [DATA_WIDTH-1:0] w_cur_byte;
    logic                  w_parity;

    assign w_in.typ   = CMD_TYPE;
    assign w_in.addr  = CMD_ADDR;
    assign w_in.d0    = CMD_D0;
    assign w_in.d1    = CMD_D1;
    assign w_in.fun   = CMD_FUN;
    assign w_in.pe    = parity_enable;
    assign w_in.pt    = parity_type;
    assign w_in.presc = (Prescale < c_PRESC_MIN) ? c_PRESC_MIN : Prescale;

`ifdef CMD_FRAME_TX_QUEUE_EN
    cmd_t       fifo_q [2];
    cmd_t       fifo_d [2];
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] cnt_q, cnt_d;
    logic       w_accept;
    logic       w_push;
    logic       w_pop;

    assign CMD_RDY  = (cnt_q != 2'd2);
    assign w_accept = CMD_VLD && CMD_RDY;
    assign w_avail  = (cnt_q != 2'd0) || w_accept;
    // An empty FIFO is bypassed so a lone command starts the cycle after accept
    assign w_next   = (cnt_q != 2'd0) ? fifo_q[rd_q] : w_in;
    assign w_chain  = 1'b1;
    assign BUSY     = (state_q != S_IDLE) || (cnt_q != 2'd0);

    // FIFO bookkeeping: push unless bypassed, pop whenever the framer loads from it
    always_comb begin
        fifo_d = fifo_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        w_pop  = w_load && (cnt_q != 2'd0);
        w_push = w_accept && !(w_load && (cnt_q == 2'd0));
        if (w_push) begin
            fifo_d[wr_q] = w_in;
            wr_d         = ~wr_q;
        end
        if (w_pop) begin
            rd_d = ~rd_q;
        end
        cnt_d = cnt_q + {1'b0, w_push} - {1'b0, w_pop};
    end

    // FIFO storage and pointers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            fifo_q <= fifo_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    assign CMD_RDY = (state_q == S_IDLE);
    assign w_avail = CMD_VLD && CMD_RDY;
    assign w_next  = w_in;
    assign w_chain = 1'b0;
    assign BUSY    = (state_q != S_IDLE);
`endif

    assign w_tc  = (timer_q == (cmd_q.presc - 1'b1));
    assign DONE  = (state_q == S_STOP) && w_tc && w_last_byte;
    assign TX_OUT = tx_q;

    // Byte selection for the active command and its last byte index
    always_comb begin
        w_cur_byte  = '0;
        w_last_byte = 1'b0;
        case (cmd_q.typ)
            c_TYPE_WR: begin
                w_last_byte = (byte_q == 2'd2);
                case (byte_q)
                    2'd0:    w_cur_byte = c_HDR_WR;
                    2'd1:    w_cur_byte = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, cmd_q.addr};
                    default: w_cur_byte = cmd_q.d0;
                endcase
            end
            c_TYPE_RD: begin
                w_last_byte = (byte_q == 2'd1);
                w_cur_byte  = (byte_q == 2'd0) ? c_HDR_RD
                                               : {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, cmd_q.addr};
            end
            c_TYPE_ALU: begin
                w_last_byte = (byte_q == 2'd3);
                case (byte_q)
                    2'd0:    w_cur_byte = c_HDR_ALU;
                    2'd1:    w_cur_byte = cmd_q.d0;
                    2'd2:    w_cur_byte = cmd_q.d1;
                    default: w_cur_byte = {{(DATA_WIDTH-OP_WIDTH){1'b0}}, cmd_q.fun};
                endcase
            end
            default: begin
                w_last_byte = (byte_q == 2'd1);
                w_cur_byte  = (byte_q == 2'd0) ? c_HDR_NOP
                                               : {{(DATA_WIDTH-OP_WIDTH){1'b0}}, cmd_q.fun};
            end
        endcase
    end

    assign w_parity = cmd_q.pt ? ~^w_cur_byte : ^w_cur_byte;

    // Next-state logic: bit timer, bit/byte/gap counters and command load
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        cmd_d   = cmd_q;
        w_load  = 1'b0;
        if (state_q != S_IDLE) begin
            timer_d = w_tc ? '0 : timer_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (w_avail) w_load = 1'b1;
            end
            S_START: begin
                if (w_tc) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_tc) begin
                    if (bit_q == c_LAST_BIT) state_d = cmd_q.pe ? S_PARITY : S_STOP;
                    else                     bit_d   = bit_q + 3'd1;
                end
            end
            S_PARITY: begin
                if (w_tc) state_d = S_STOP;
            end
            S_STOP: begin
                if (w_tc) begin
                    if (!w_last_byte) begin
                        if (GAP_BITS > 0) begin
                            state_d = S_GAP;
                            gap_d   = 3'd0;
                        end else begin
                            state_d = S_START;
                            byte_d  = byte_q + 2'd1;
                        end
                    end else if (w_chain && w_avail) begin
                        w_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (w_tc) begin
                    if (gap_q == c_GAP_LAST) begin
                        state_d = S_START;
                        byte_d  = byte_q + 2'd1;
                    end else begin
                        gap_d = gap_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (w_load) begin
            state_d = S_START;
            timer_d = '0;
            bit_d   = 3'd0;
            byte_d  = 2'd0;
            gap_d   = 3'd0;
            cmd_d   = w_next;
        end
    end

    // Line value for the coming cycle, registered so TX_OUT never glitches
    always_comb begin
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = w_cur_byte[bit_d];
            S_PARITY: tx_d = w_parity;
            default:  tx_d = 1'b1;
        endcase
    end

    // Framer state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            gap_q   <= 3'd0;
            tx_q    <= 1'b1;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            cmd_q   <= cmd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cmd_frame_tx                                              |
// | Description : Directed self-checking bench for cmd_frame_tx. Expected      |
// |               bytes are queued at drive time and checked by a serial       |
// |               line receiver; command durations come from the frame-length  |
// |               formula.                                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cmd_frame_tx;

    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_vld = 1'b0;
    logic       cmd_rdy;
    logic [1:0] cmd_type = 2'd0;
    logic [3:0] cmd_addr = 4'h0;
    logic [7:0] cmd_d0 = 8'h00;
    logic [7:0] cmd_d1 = 8'h00;
    logic [3:0] cmd_fun = 4'h0;
    logic       par_en = 1'b0;
    logic       par_type = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic       tx_out;
    logic       busy;
    logic       done;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cycle_no = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];
    int         mon_p = 8;
    logic       mon_pe = 1'b0;
    logic       mon_pt = 1'b0;
    logic       mon_abort = 1'b0;
    logic       busy_low = 1'b0;

    cmd_frame_tx #(.GAP_BITS(GAP)) dut (
        .CLK           (clk),
        .RST           (rst),
        .CMD_VLD       (cmd_vld),
        .CMD_RDY       (cmd_rdy),
        .CMD_TYPE      (cmd_type),
        .CMD_ADDR      (cmd_addr),
        .CMD_D0        (cmd_d0),
        .CMD_D1        (cmd_d1),
        .CMD_FUN       (cmd_fun),
        .parity_enable (par_en),
        .parity_type   (par_type),
        .Prescale      (prescale),
        .TX_OUT        (tx_out),
        .BUSY          (busy),
        .DONE          (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle_no++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] t);
        case (t)
            2'd0:    return 3;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int dur(input logic [1:0] t, input int pe, input int p);
        return nbytes(t) * (10 + pe) * p + (nbytes(t) - 1) * GAP * p;
    endfunction

    task automatic set_cfg(input int p, input logic pe, input logic pt);
        prescale = 6'(p);
        par_en   = pe;
        par_type = pt;
        mon_p    = (p < 4) ? 4 : p;
        mon_pe   = pe;
        mon_pt   = pt;
    endtask

    // Present a command and queue the bytes it must produce on the line
    task automatic drive_cmd(input logic [1:0] t, input logic [3:0] a,
                             input logic [7:0] d0, input logic [7:0] d1, input logic [3:0] f);
        cmd_type = t; cmd_addr = a; cmd_d0 = d0; cmd_d1 = d1; cmd_fun = f;
        cmd_vld  = 1'b1;
        case (t)
            2'd0: begin exp_q.push_back(8'hAA); exp_q.push_back({4'h0, a}); exp_q.push_back(d0); end
            2'd1: begin exp_q.push_back(8'hBB); exp_q.push_back({4'h0, a}); end
            2'd2: begin exp_q.push_back(8'hCC); exp_q.push_back(d0); exp_q.push_back(d1);
                        exp_q.push_back({4'h0, f}); end
            default: begin exp_q.push_back(8'hDD); exp_q.push_back({4'h0, f}); end
        endcase
    endtask

    // Drive, wait for the handshake, return the cycle number just after accept
    task automatic send(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d0,
                        input logic [7:0] d1, input logic [3:0] f, output int t_acc);
        int w;
        drive_cmd(t, a, d0, d1, f);
        w = 0;
        while (cmd_rdy !== 1'b1 && w < 2000) begin
            cyc_wait(1);
            w++;
        end
        chk("accept_ready", cmd_rdy, 1);
        cyc_wait(1);
        cmd_vld = 1'b0;
        t_acc   = cycle_no;
    endtask

    // Wait (bounded) for the next DONE and check its cycle relative to t_ref
    task automatic wait_done(input string tag, input int t_ref, input int exp_rel);
        int k;
        k = 0;
        do begin
            cyc_wait(1);
            k++;
            if (busy !== 1'b1) busy_low = 1'b1;
        end while (done !== 1'b1 && k < 5000);
        chk(tag, cycle_no - t_ref + 1, exp_rel);
    endtask

    task automatic post(input string tag, input int base, input int n_done);
        cyc_wait(1);
        chk({tag, "_busy_off"}, busy, 0);
        chk({tag, "_rdy_on"}, cmd_rdy, 1);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        chk({tag, "_done_pulses"}, done_cnt - base, n_done);
        chk({tag, "_busy_cont"}, busy_low, 0);
    endtask

    // Serial receiver: finds each start bit and samples every bit mid-period
    initial begin : rx_monitor
        logic       prev, st, sp, par;
        logic [7:0] b, e;
        prev = 1'b1;
        par  = 1'b0;
        forever begin
            cyc_wait(1);
            if (prev === 1'b1 && tx_out === 1'b0) begin
                cyc_wait(mon_p / 2);
                st = tx_out;
                for (int i = 0; i < 8; i++) begin
                    cyc_wait(mon_p);
                    b[i] = tx_out;
                end
                if (mon_pe) begin
                    cyc_wait(mon_p);
                    par = tx_out;
                end
                cyc_wait(mon_p);
                sp = tx_out;
                if (!mon_abort) begin
                    chk("start_bit", st, 0);
                    chk("stop_bit", sp, 1);
                    chk("byte_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("rx_byte", b, e);
                        if (mon_pe) chk("rx_parity", par, mon_pt ? ~^e : ^e);
                    end
                end
            end
            prev = tx_out;
        end
    end

    initial begin : stimulus
        int  ta, tb, tc, td, base;
        logic tx_bad;

        set_cfg(8, 1'b0, 1'b0);
        cyc_wait(3);
        chk("rst_tx", tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdy", cmd_rdy, 1);
        rst = 1'b0;
        cyc_wait(2);

        // WR addr 3 data 5A, P=8, no parity
        base = done_cnt; busy_low = 1'b0;
        send(2'd0, 4'h3, 8'h5A, 8'h00, 4'h0, ta);
        chk("wr_busy_first", busy, 1);
        chk("wr_tx_start", tx_out, 0);
        wait_done("wr_done_cycle", ta, dur(2'd0, 0, 8));
        post("wr", base, 1);

        // RD addr 2, odd parity, P=8
        set_cfg(8, 1'b1, 1'b1);
        base = done_cnt; busy_low = 1'b0;
        send(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, ta);
        wait_done("rd_odd_done_cycle", ta, dur(2'd1, 1, 8));
        post("rd_odd", base, 1);

        // ALU_OP, even parity, odd prescale
        set_cfg(5, 1'b1, 1'b0);
        base = done_cnt; busy_low = 1'b0;
        send(2'd2, 4'h0, 8'h37, 8'hF0, 4'hE, ta);
        wait_done("alu_even_done_cycle", ta, dur(2'd2, 1, 5));
        post("alu_even", base, 1);

        // Prescale below minimum behaves as 4
        set_cfg(2, 1'b0, 1'b0);
        base = done_cnt; busy_low = 1'b0;
        send(2'd3, 4'h0, 8'h00, 8'h00, 4'h9, ta);
        wait_done("p2_done_cycle", ta, dur(2'd3, 0, 4));
        post("p2", base, 1);

        // Prescale changed mid-command does not disturb the active command
        base = done_cnt; busy_low = 1'b0;
        send(2'd1, 4'hA, 8'h00, 8'h00, 4'h0, ta);
        cyc_wait(10);
        prescale = 6'd12;
        wait_done("presc_chg_done_cycle", ta, dur(2'd1, 0, 4));
        post("presc_chg", base, 1);

`ifdef CMD_FRAME_TX_QUEUE_EN
        // Back-to-back through the FIFO, then a stalled command
        set_cfg(8, 1'b0, 1'b0);
        base = done_cnt; busy_low = 1'b0;
        send(2'd2, 4'h0, 8'h10, 8'h20, 4'h1, ta);
        send(2'd3, 4'h0, 8'h00, 8'h00, 4'h4, tb);
        send(2'd0, 4'h7, 8'hC3, 8'h00, 4'h0, tc);
        drive_cmd(2'd1, 4'h5, 8'h00, 8'h00, 4'h0);
        cyc_wait(3);
        chk("q_full_stall", cmd_rdy, 0);
        wait_done("q_done1", ta, dur(2'd2, 0, 8));
        chk("q_stall_at_done", cmd_rdy, 0);
        cyc_wait(1);
        cmd_vld = 1'b0;
        chk("q_full_after_swap", cmd_rdy, 0);
        td = dur(2'd2, 0, 8) + dur(2'd3, 0, 8);
        wait_done("q_done2", ta, td);
        td = td + dur(2'd0, 0, 8);
        wait_done("q_done3", ta, td);
        td = td + dur(2'd1, 0, 8);
        wait_done("q_done4", ta, td);
        post("queue", base, 4);
`else
        // A command offered while busy is held off until the framer is idle
        set_cfg(8, 1'b1, 1'b0);
        base = done_cnt; busy_low = 1'b0;
        send(2'd0, 4'h9, 8'h66, 8'h00, 4'h0, ta);
        drive_cmd(2'd1, 4'h5, 8'h00, 8'h00, 4'h0);
        cyc_wait(20);
        chk("stall_rdy_low", cmd_rdy, 0);
        wait_done("stall_a_done", ta, dur(2'd0, 1, 8));
        chk("stall_rdy_at_done", cmd_rdy, 0);
        cyc_wait(1);
        chk("stall_rdy_after_done", cmd_rdy, 1);
        cyc_wait(1);
        cmd_vld = 1'b0;
        tb = cycle_no;
        chk("stall_b_started", busy, 1);
        wait_done("stall_b_done", tb, dur(2'd1, 1, 8));
        post("stall", base, 2);
`endif

        // Reset asserted inside the 4th byte of an ALU_OP
        set_cfg(4, 1'b0, 1'b0);
        base = done_cnt;
        send(2'd2, 4'h0, 8'h10, 8'h20, 4'h1, ta);
        void'(exp_q.pop_back());
        while (cycle_no - ta + 1 < 3 * (10 + GAP) * 4 + 7) cyc_wait(1);
        mon_abort = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_tx", tx_out, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rdy", cmd_rdy, 1);
        chk("rst_mid_done", done, 0);
        cyc_wait(2);
        rst = 1'b0;
        tx_bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc_wait(1);
            if (tx_out !== 1'b1) tx_bad = 1'b1;
        end
        chk("rst_mid_line_idle", tx_bad, 0);
        chk("rst_mid_no_done", done_cnt - base, 0);
        chk("rst_mid_sb_empty", exp_q.size(), 0);
        mon_abort = 1'b0;

        // Recovery after reset
        set_cfg(4, 1'b1, 1'b0);
        base = done_cnt; busy_low = 1'b0;
        send(2'd1, 4'hF, 8'h00, 8'h00, 4'h0, ta);
        wait_done("recover_done_cycle", ta, dur(2'd1, 1, 4));
        post("recover", base, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
